// File: rtl/vedic_mac_accumulator.sv
// ---------------------------------------------------------------------------
// vedic_mac_accumulator
//
// Sums a fixed number (N_TERMS) of unsigned 8-bit products, delivered over a
// valid/ready handshake, into one ACC_W-bit dot-product result. An overflow
// either saturates at all-ones (SAT=1) or wraps modulo 2^ACC_W (SAT=0). In
// both modes the result carries a sticky overflow flag. Each completed result
// is held in an output register until downstream takes it.
//
// Ports:
//   clk        - single clock, rising-edge active
//   rst_n      - asynchronous active-low reset
//   ena        - global enable; low freezes every register
//   clr        - synchronous clear of partial sum and held result
//   in_valid   - in_prod carries a product
//   in_ready   - block accepts a product this cycle
//   in_prod    - unsigned 8-bit product
//   out_valid  - out_sum / out_ovf hold a completed result
//   out_ready  - downstream accepts the result
//   out_sum    - completed sum (ACC_W bits)
//   out_ovf    - overflow occurred while building this result
// ---------------------------------------------------------------------------
module vedic_mac_accumulator #(
    parameter int unsigned ACC_W   = 16,
    parameter int unsigned N_TERMS = 4,
    parameter bit          SAT     = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_prod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);

    // Term counter must reach N_TERMS-1; keep at least one bit for N_TERMS=1.
    localparam int unsigned CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TERMS - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    state_e           state_q,     state_d;
    logic [ACC_W-1:0] acc_q,       acc_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             ovf_acc_q,   ovf_acc_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_sum_q,   out_sum_d;
    logic             out_ovf_q,   out_ovf_d;

    logic             accept;
    logic [ACC_W:0]   sum_ext;
    logic             carry;
    logic [ACC_W-1:0] next_acc;
    logic             last_term;

    // in_ready depends only on registered state, ena and clr; out_ready never
    // reaches it combinationally.
    assign in_ready  = ena & ~clr & (state_q == ACCUM);
    assign accept    = in_valid & in_ready;

    // One extra bit captures the carry out of the accumulator.
    assign sum_ext   = {1'b0, acc_q} + {{(ACC_W + 1 - 8){1'b0}}, in_prod};
    assign carry     = sum_ext[ACC_W];
    assign last_term = (cnt_q == CNT_LAST);

    // Once saturated, acc is all-ones, so any further non-zero term carries
    // again and re-saturates: saturation stays sticky without extra state.
    always_comb begin
        next_acc = sum_ext[ACC_W-1:0];
        if (carry && SAT) begin
            next_acc = '1;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_acc_d   = ovf_acc_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_ovf_d   = out_ovf_q;

        if (clr) begin
            // clr wins over accept and output handshake; the last result
            // value stays visible but is no longer flagged valid.
            state_d     = ACCUM;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_acc_d   = 1'b0;
            out_valid_d = 1'b0;
        end else if (ena) begin
            if (accept) begin
                if (last_term) begin
                    out_sum_d   = next_acc;
                    out_ovf_d   = ovf_acc_q | carry;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                    cnt_d       = '0;
                    ovf_acc_d   = 1'b0;
                    state_d     = HOLD;
                end else begin
                    acc_d     = next_acc;
                    cnt_d     = cnt_q + CNT_W'(1);
                    ovf_acc_d = ovf_acc_q | carry;
                end
            end else if ((state_q == HOLD) && out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
                state_d     = ACCUM;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_acc_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_acc_q   <= ovf_acc_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_vedic_mac_accumulator.sv
// ---------------------------------------------------------------------------
// tb_vedic_mac_accumulator
//
// Drives three accumulator configurations from shared stimulus:
//   u0: ACC_W=16, N_TERMS=4, SAT=1 (defaults)
//   u1: ACC_W=8,  N_TERMS=2, SAT=1
//   u2: ACC_W=8,  N_TERMS=2, SAT=0
// A reference model collects accepted terms per configuration and folds
// them into a result only when a full set of N_TERMS has been gathered.
// ---------------------------------------------------------------------------
module tb_vedic_mac_accumulator;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       clr;
    logic       in_valid;
    logic [7:0] in_prod;
    logic       out_ready;

    logic        rdy0, rdy1, rdy2;
    logic        vld0, vld1, vld2;
    logic        ovf0, ovf1, ovf2;
    logic [15:0] sum0;
    logic [7:0]  sum1, sum2;

    vedic_mac_accumulator #(.ACC_W(16), .N_TERMS(4), .SAT(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr),
        .in_valid(in_valid), .in_ready(rdy0), .in_prod(in_prod),
        .out_valid(vld0), .out_ready(out_ready), .out_sum(sum0), .out_ovf(ovf0)
    );

    vedic_mac_accumulator #(.ACC_W(8), .N_TERMS(2), .SAT(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr),
        .in_valid(in_valid), .in_ready(rdy1), .in_prod(in_prod),
        .out_valid(vld1), .out_ready(out_ready), .out_sum(sum1), .out_ovf(ovf1)
    );

    vedic_mac_accumulator #(.ACC_W(8), .N_TERMS(2), .SAT(1'b0)) u2 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr),
        .in_valid(in_valid), .in_ready(rdy2), .in_prod(in_prod),
        .out_valid(vld2), .out_ready(out_ready), .out_sum(sum2), .out_ovf(ovf2)
    );

    logic [31:0] o_sum   [3];
    logic        o_valid [3];
    logic        o_ovf   [3];
    logic        o_ready [3];

    assign o_sum[0]   = 32'(sum0);
    assign o_sum[1]   = 32'(sum1);
    assign o_sum[2]   = 32'(sum2);
    assign o_valid[0] = vld0;
    assign o_valid[1] = vld1;
    assign o_valid[2] = vld2;
    assign o_ovf[0]   = ovf0;
    assign o_ovf[1]   = ovf1;
    assign o_ovf[2]   = ovf2;
    assign o_ready[0] = rdy0;
    assign o_ready[1] = rdy1;
    assign o_ready[2] = rdy2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Configuration of each instance, as seen by the model.
    int unsigned P_W [3] = '{16, 8, 8};
    int unsigned P_N [3] = '{4, 2, 2};
    bit          P_S [3] = '{1'b1, 1'b1, 1'b0};

    // Reference model state.
    bit          m_hold  [3];
    longint      m_sum   [3];
    bit          m_ovf   [3];
    int unsigned m_n     [3];
    int unsigned m_terms [3][256];

    int unsigned total;
    int unsigned passed;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Sum the collected terms with the overflow rule of the given instance.
    task automatic fold(input int k, output longint res, output bit ov);
        longint lim;
        longint s;
        lim = longint'(1) << P_W[k];
        res = 0;
        ov  = 1'b0;
        for (int unsigned j = 0; j < m_n[k]; j++) begin
            s = res + longint'(m_terms[k][j]);
            if (s >= lim) begin
                ov = 1'b1;
                s  = P_S[k] ? (lim - 1) : (s - lim);
            end
            res = s;
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_hold[k] = 1'b0;
            m_sum[k]  = 0;
            m_ovf[k]  = 1'b0;
            m_n[k]    = 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s.u%0d.out_valid", tag, k), 32'(o_valid[k]), 32'(m_hold[k]));
            chk($sformatf("%s.u%0d.out_sum",   tag, k), o_sum[k],         32'(m_sum[k]));
            chk($sformatf("%s.u%0d.out_ovf",   tag, k), 32'(o_ovf[k]),   32'(m_ovf[k]));
        end
    endtask

    // One clock cycle: drive inputs just after a falling edge, check
    // in_ready, advance the model across the rising edge, then check the
    // registered outputs at the next falling edge.
    task automatic cycle(input string tag, input bit v, input logic [7:0] p,
                         input bit ordy, input bit e, input bit c);
        bit     rdy;
        longint res;
        bit     ov;
        in_valid  = v;
        in_prod   = p;
        out_ready = ordy;
        ena       = e;
        clr       = c;
        #1;
        for (int k = 0; k < 3; k++) begin
            rdy = e & ~c & ~m_hold[k];
            chk($sformatf("%s.u%0d.in_ready", tag, k), 32'(o_ready[k]), 32'(rdy));
            if (c) begin
                m_hold[k] = 1'b0;
                m_n[k]    = 0;
            end else if (e) begin
                if (rdy && v) begin
                    m_terms[k][m_n[k]] = int'(p);
                    m_n[k]++;
                    if (m_n[k] == P_N[k]) begin
                        fold(k, res, ov);
                        m_sum[k]  = res;
                        m_ovf[k]  = ov;
                        m_hold[k] = 1'b1;
                        m_n[k]    = 0;
                    end
                end else if (m_hold[k] && ordy) begin
                    m_hold[k] = 1'b0;
                end
            end
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    initial begin
        total     = 0;
        passed    = 0;
        rst_n     = 1'b0;
        ena       = 1'b1;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_prod   = '0;
        out_ready = 1'b0;
        model_reset();

        @(negedge clk);
        check_outputs("reset");
        rst_n = 1'b1;

        // Basic sum: four accepts of 225.
        for (int i = 0; i < 4; i++) cycle("basic", 1'b1, 8'd225, 1'b0, 1'b1, 1'b0);
        chk("basic.u0.sum_900", o_sum[0], 32'd900);
        chk("basic.u0.valid",   32'(o_valid[0]), 32'd1);
        chk("basic.u0.ovf",     32'(o_ovf[0]), 32'd0);

        // Backpressure: result held, no accepts.
        for (int i = 0; i < 5; i++) cycle("bp", 1'b1, 8'd17, 1'b0, 1'b1, 1'b0);
        chk("bp.u0.sum_held", o_sum[0], 32'd900);
        cycle("bp_rel", 1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
        chk("bp_rel.u0.valid_low", 32'(o_valid[0]), 32'd0);
        cycle("bp_idle", 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);

        // Saturation / wrap on the 8-bit instances.
        cycle("align", 1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
        cycle("ovf", 1'b1, 8'd200, 1'b0, 1'b1, 1'b0);
        cycle("ovf", 1'b1, 8'd100, 1'b0, 1'b1, 1'b0);
        chk("sat.u1.sum_255",  o_sum[1], 32'd255);
        chk("sat.u1.ovf",      32'(o_ovf[1]), 32'd1);
        chk("wrap.u2.sum_44",  o_sum[2], 32'd44);
        chk("wrap.u2.ovf",     32'(o_ovf[2]), 32'd1);
        cycle("ovf_ack", 1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
        cycle("small", 1'b1, 8'd3, 1'b0, 1'b1, 1'b0);
        cycle("small", 1'b1, 8'd4, 1'b0, 1'b1, 1'b0);
        chk("sat.u1.sum_7",  o_sum[1], 32'd7);
        chk("sat.u1.ovf_0",  32'(o_ovf[1]), 32'd0);
        cycle("small_ack", 1'b0, 8'd0, 1'b1, 1'b1, 1'b0);

        // clr abandons the partial sum.
        cycle("clr", 1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
        cycle("clr", 1'b1, 8'd50, 1'b0, 1'b1, 1'b0);
        cycle("clr", 1'b1, 8'd60, 1'b0, 1'b1, 1'b0);
        cycle("clr", 1'b1, 8'd99, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cycle("clr_ones", 1'b1, 8'd1, 1'b0, 1'b1, 1'b0);
        chk("clr.u0.sum_4", o_sum[0], 32'd4);

        // ena low freezes the block while in_valid stays high.
        cycle("ena", 1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
        cycle("ena", 1'b1, 8'd5, 1'b0, 1'b1, 1'b0);
        cycle("ena", 1'b1, 8'd6, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle("ena_off", 1'b1, 8'd77, 1'b1, 1'b0, 1'b0);
        cycle("ena", 1'b1, 8'd7, 1'b0, 1'b1, 1'b0);
        cycle("ena", 1'b1, 8'd8, 1'b0, 1'b1, 1'b0);
        chk("ena.u0.sum_26", o_sum[0], 32'd26);

        // Asynchronous reset between edges, mid-result.
        cycle("rst", 1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
        cycle("rst", 1'b1, 8'd30, 1'b0, 1'b1, 1'b0);
        cycle("rst", 1'b1, 8'd40, 1'b0, 1'b1, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        chk("async_rst.u1.sum_0", o_sum[1], 32'd0);
        @(negedge clk);
        check_outputs("rst_hold");
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cycle("post_rst", 1'b1, 8'd10, 1'b0, 1'b1, 1'b0);
        chk("post_rst.u0.sum_40", o_sum[0], 32'd40);
        cycle("post_rst_ack", 1'b0, 8'd0, 1'b1, 1'b1, 1'b0);

        // Randomized traffic, full 0..255 product range.
        for (int i = 0; i < 600; i++) begin
            cycle("rand",
                  ($urandom_range(0, 3) != 0),
                  8'($urandom_range(0, 255)),
                  ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 39) == 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/vedic_mac_accumulator.md
# vedic_mac_accumulator

Downstream consumer of the 4x4 Vedic multiplier. It accepts 8-bit products over a valid/ready handshake and sums a fixed number of them (N_TERMS) into a dot-product result, with saturation or wrap-around on overflow. It presents each completed result on a held output register with its own valid/ready handshake. Together with the multiplier it forms the MAC datapath of the design.

## Interface
Parameters:
- ACC_W, 16, accumulator and result width; legal range 8..24.
- N_TERMS, 4, products summed per result; legal range 1..256.
- SAT, 1, overflow mode: 1 = saturate at 2^ACC_W-1; 0 = wrap modulo 2^ACC_W.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ena  input  1  global enable; when low, all state is frozen.
- clr  input  1  synchronous clear; abandons the partial sum and any held result.
- in_valid  input  1  in_prod is valid.
- in_ready  output  1  block can accept a product this cycle.
- in_prod  input  8  unsigned product, 0..225 from the multiplier; full 0..255 must still work.
- out_valid  output  1  out_sum and out_ovf hold a completed result.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  ACC_W  completed sum.
- out_ovf  output  1  overflow occurred during this result (sticky per result).

## Operation
- FSM states: ACCUM (reset state) and HOLD.
- Internal registers: acc[ACC_W-1:0], cnt (covers 0..N_TERMS-1), ovf_acc.
- in_ready = ena & ~clr & (state==ACCUM). This is combinational, so in_ready is high immediately after reset if ena is high.
- Accept occurs when in_valid & in_ready. On accept, next = acc + in_prod, computed at ACC_W+1 bits.
  - If the carry bit is set: with SAT=1, next = all-ones; with SAT=0, next = low ACC_W bits. In both modes, ovf_acc is set.
- Accept with cnt < N_TERMS-1: acc <= next, cnt <= cnt+1.
- Accept with cnt == N_TERMS-1:
  - out_sum <= next; out_ovf <= ovf_acc | carry; out_valid <= 1.
  - acc, cnt and ovf_acc are cleared; state goes to HOLD.
- HOLD:
  - in_ready = 0.
  - out_sum, out_ovf and out_valid stay stable until out_valid & out_ready & ena.
  - On that handshake, out_valid <= 0 and state goes to ACCUM.
- Saturation is sticky within a result: once acc saturates at all-ones, it stays at all-ones for the remaining terms.
- clr (with ena high or low) on a rising edge:
  - state <= ACCUM; acc, cnt, ovf_acc <= 0; out_valid <= 0.
  - out_sum and out_ovf keep their last value.
  - clr takes priority over any accept or output handshake in the same cycle.
- ena low and clr low: no register changes, in_ready = 0, and an output handshake is ignored. out_valid holds its value.
- N_TERMS=1: every accept goes straight to HOLD with out_sum = in_prod.

## Timing
- Reset values: state=ACCUM, acc=0, cnt=0, ovf_acc=0, out_valid=0, out_sum=0, out_ovf=0.
- Asynchronous reset takes effect immediately, mid-operation included. Any partial sum and any held result are discarded.
- Latency: when the last term is accepted at edge k, out_valid is high after edge k and out_sum is valid in the same cycle.
- The first accept of the next result can occur at edge k+2 at the earliest: handshake at k+1, in_ready high after k+1.
- Throughput: one product per cycle while in ACCUM. Each result costs at least one extra cycle in HOLD.
- No combinational path from out_ready to in_ready; in_ready depends only on registered state, ena and clr.

## Test plan
- Basic sum: defaults; four accepts of 225 back-to-back -> one cycle after the fourth accept, out_valid=1, out_sum=900 (0x0384), out_ovf=0; in_ready=0 until out_ready.
- Backpressure: as above, but hold out_ready low for 5 cycles -> out_sum stays 900 and in_ready stays 0. Raise out_ready -> out_valid drops one edge later and in_ready rises.
- Saturation: ACC_W=8, SAT=1, N_TERMS=2; products 200 then 100 -> out_sum=255, out_ovf=1. Next result of 3 then 4 -> out_sum=7, out_ovf=0.
- Wrap: ACC_W=8, SAT=0, N_TERMS=2; products 200 then 100 -> out_sum=44, out_ovf=1.
- clr and ena:
  - Accept 50 and 60, pulse clr, then four accepts of 1 -> out_sum=4.
  - Drop ena for 3 cycles between accepts while in_valid stays high -> no accepts during that window; final sum unchanged.
- Reset mid-operation: accept two terms, then assert rst_n low asynchronously (between edges) -> all outputs read 0 at once. After release, four accepts of 10 -> out_sum=40.
